// File: rtl/piso_shift_register.sv
// Parallel-in serial-out shift register with a valid/ready load port.
// It supports back-to-back frames: the next word loads on the edge that consumes the last bit.
module piso_shift_register #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_pin,
    input  logic             i_load_valid,
    output logic             o_load_ready,
    input  logic             i_shift_en,
    output logic             o_sout,
    output logic             o_sout_valid,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [WIDTH-1:0]  r_sreg;
    logic [WIDTH-1:0]  w_sreg_nxt;
    logic [CntW-1:0]   r_cnt;
    logic [CntW-1:0]   w_cnt_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              w_last_bit;
    logic              w_accept;
    logic              w_out_bit;
    logic [WIDTH-1:0]  w_shifted;

    // Shift toward the output end, filling with zeros behind.
    assign w_shifted = MSB_FIRST ? {r_sreg[WIDTH-2:0], 1'b0} : {1'b0, r_sreg[WIDTH-1:1]};
    assign w_out_bit = MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0];

    assign w_last_bit   = (r_state == StShift) && (r_cnt == '0) && i_shift_en;
    assign o_load_ready = (r_state == StIdle) || w_last_bit;
    assign w_accept     = i_load_valid && o_load_ready;

    assign o_sout       = (r_state == StShift) && w_out_bit;
    assign o_sout_valid = (r_state == StShift);
    assign o_busy       = (r_state == StShift);
    assign o_done       = r_done;

    always_comb begin
        w_state_nxt = r_state;
        w_sreg_nxt  = r_sreg;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_sreg_nxt  = i_pin;
                    w_cnt_nxt   = CntLast;
                    w_state_nxt = StShift;
                end
            end
            StShift: begin
                if (i_shift_en) begin
                    if (r_cnt != '0) begin
                        w_sreg_nxt = w_shifted;
                        w_cnt_nxt  = r_cnt - 1'b1;
                    end else begin
                        w_done_nxt = 1'b1;
                        if (w_accept) begin
                            w_sreg_nxt = i_pin;
                            w_cnt_nxt  = CntLast;
                        end else begin
                            w_sreg_nxt  = '0;
                            w_state_nxt = StIdle;
                        end
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_sreg  <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sreg  <= w_sreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_piso_shift_register.sv
// Directed bench: a 4-bit MSB-first and an 8-bit LSB-first instance share clock and reset.
module tb_piso_shift_register;

    logic       clk;
    logic       rst_n;
    logic       va, ea, ra, sa, sva, ba, da;
    logic [3:0] pa;
    logic       vb, eb, rb, sb, svb, bb, db;
    logic [7:0] pb;

    int unsigned errors;
    int unsigned checks;

    piso_shift_register #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut_a (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_pin        (pa),
        .i_load_valid (va),
        .o_load_ready (ra),
        .i_shift_en   (ea),
        .o_sout       (sa),
        .o_sout_valid (sva),
        .o_busy       (ba),
        .o_done       (da)
    );

    piso_shift_register #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_b (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_pin        (pb),
        .i_load_valid (vb),
        .o_load_ready (rb),
        .i_shift_en   (eb),
        .o_sout       (sb),
        .o_sout_valid (svb),
        .o_busy       (bb),
        .o_done       (db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic drive_a(input logic v, input logic [3:0] p, input logic e);
        @(negedge clk);
        va = v; pa = p; ea = e;
        #1;
    endtask

    task automatic drive_b(input logic v, input logic [7:0] p, input logic e);
        @(negedge clk);
        vb = v; pb = p; eb = e;
        #1;
    endtask

    task automatic check_a_idle(input string tag);
        check({tag, "_sout"}, sa, 0);
        check({tag, "_valid"}, sva, 0);
        check({tag, "_busy"}, ba, 0);
        check({tag, "_done"}, da, 0);
    endtask

    logic [0:3] seq1  = 4'b1011;
    logic [0:7] seq2  = 8'b0111_1000;
    logic [0:7] seq3  = 8'b1010_0101;
    logic [0:6] en4   = 7'b1001101;
    logic [0:6] seq4  = 7'b1111000;
    logic [0:3] seq6  = 4'b0110;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        va = 0; pa = '0; ea = 0;
        vb = 0; pb = '0; eb = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_a_idle("rst_a");
        check("rst_a_ready", ra, 1);
        check("rst_b_valid", svb, 0);
        check("rst_b_sout", sb, 0);
        check("rst_b_done", db, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: 4'b1011 MSB first.
        drive_a(1, 4'b1011, 1);
        check("t1_ready_idle", ra, 1);
        check("t1_valid_idle", sva, 0);
        for (int i = 1; i <= 6; i++) begin
            drive_a(0, 4'h0, 1);
            if (i <= 4) begin
                check($sformatf("t1_sout%0d", i), sa, seq1[i-1]);
                check($sformatf("t1_valid%0d", i), sva, 1);
                check($sformatf("t1_busy%0d", i), ba, 1);
            end else begin
                check($sformatf("t1_sout%0d", i), sa, 0);
                check($sformatf("t1_valid%0d", i), sva, 0);
            end
            check($sformatf("t1_done%0d", i), da, i == 5);
            check($sformatf("t1_ready%0d", i), ra, i >= 4);
        end

        // Test 2: 8'h1E LSB first on the wide instance.
        drive_b(1, 8'h1E, 1);
        for (int i = 1; i <= 10; i++) begin
            drive_b(0, 8'h00, 1);
            if (i <= 8) begin
                check($sformatf("t2_sout%0d", i), sb, seq2[i-1]);
                check($sformatf("t2_valid%0d", i), svb, 1);
            end else begin
                check($sformatf("t2_valid%0d", i), svb, 0);
            end
            check($sformatf("t2_done%0d", i), db, i == 9);
        end

        // Test 3: back-to-back 4'hA then 4'h5 with valid held.
        drive_a(1, 4'hA, 1);
        for (int i = 1; i <= 9; i++) begin
            drive_a(i <= 7, 4'h5, 1);
            if (i <= 8) begin
                check($sformatf("t3_sout%0d", i), sa, seq3[i-1]);
                check($sformatf("t3_valid%0d", i), sva, 1);
                check($sformatf("t3_ready%0d", i), ra, (i == 4) || (i == 8));
            end else begin
                check($sformatf("t3_valid%0d", i), sva, 0);
            end
            check($sformatf("t3_done%0d", i), da, (i == 5) || (i == 9));
        end

        // Test 4: shift-enable gaps hold each bit.
        drive_a(1, 4'b1100, 1);
        for (int i = 1; i <= 7; i++) begin
            drive_a(0, 4'h0, en4[i-1]);
            check($sformatf("t4_sout%0d", i), sa, seq4[i-1]);
            check($sformatf("t4_valid%0d", i), sva, 1);
            check($sformatf("t4_done%0d", i), da, 0);
            check($sformatf("t4_ready%0d", i), ra, i == 7);
        end
        drive_a(0, 4'h0, 1);
        check("t4_done_end", da, 1);
        check("t4_valid_end", sva, 0);

        // Test 5: load attempt mid-frame is ignored.
        drive_a(1, 4'h0, 1);
        for (int i = 1; i <= 5; i++) begin
            drive_a(i == 2, 4'hF, 1);
            if (i <= 4) begin
                check($sformatf("t5_sout%0d", i), sa, 0);
                check($sformatf("t5_valid%0d", i), sva, 1);
            end else begin
                check($sformatf("t5_valid%0d", i), sva, 0);
            end
            check($sformatf("t5_done%0d", i), da, i == 5);
        end

        // Test 6: asynchronous clear mid-frame, then a fresh load.
        drive_a(1, 4'b1011, 1);
        drive_a(0, 4'h0, 1);
        check("t6_bit1", sa, 1);
        drive_a(0, 4'h0, 1);
        check("t6_bit2", sa, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_a_idle("t6_clr");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_a_idle($sformatf("t6_hold%0d", i));
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_a(1, 4'b0110, 1);
        check("t6_ready", ra, 1);
        check("t6_done_none", da, 0);
        for (int i = 1; i <= 5; i++) begin
            drive_a(0, 4'h0, 1);
            if (i <= 4) begin
                check($sformatf("t6_sout%0d", i), sa, seq6[i-1]);
                check($sformatf("t6_valid%0d", i), sva, 1);
            end
            check($sformatf("t6_done%0d", i), da, i == 5);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
